// File: rtl/ahb_slave_interface_if.sv
// -----------------------------------------------------------------------------
// ahb_slave_interface_if
//
// Purpose: groups the AHB-side and APB-controller-side signals of the
// AHB-to-APB bridge front end so they can be passed as a single port.
//
// Signals:
//   hwrite       AHB transfer direction (1 = write)
//   hready_in    AHB HREADY seen by the slave
//   htrans       AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
//   haddr        AHB address
//   hwdata       AHB write data
//   prdata       APB read data from the selected peripheral
//   hr_readyout  ready from the APB controller
//   valid        qualified, mapped transfer in the current address phase
//   haddr1/2     haddr delayed by one / two captures
//   hwdata1/2    hwdata delayed by one / two captures
//   hwrite_reg/1 hwrite delayed by one / two captures
//   temp_selx    one-hot peripheral select
//   hrdata       read data returned to the master
//   hresp        AHB response (0 OKAY, 1 ERROR)
//   hready_out   HREADYOUT to the master
//
// Modports:
//   slave  - view used by the bridge front end
//   master - view used by whatever drives the bus (master + APB controller)
// -----------------------------------------------------------------------------
interface ahb_slave_interface_if;

    logic        hwrite;
    logic        hready_in;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        hr_readyout;

    logic        valid;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [31:0] hwdata2;
    logic        hwrite_reg;
    logic        hwrite_reg1;
    logic [2:0]  temp_selx;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready_out;

    modport slave (
        input  hwrite,
        input  hready_in,
        input  htrans,
        input  haddr,
        input  hwdata,
        input  prdata,
        input  hr_readyout,
        output valid,
        output haddr1,
        output haddr2,
        output hwdata1,
        output hwdata2,
        output hwrite_reg,
        output hwrite_reg1,
        output temp_selx,
        output hrdata,
        output hresp,
        output hready_out
    );

    modport master (
        output hwrite,
        output hready_in,
        output htrans,
        output haddr,
        output hwdata,
        output prdata,
        output hr_readyout,
        input  valid,
        input  haddr1,
        input  haddr2,
        input  hwdata1,
        input  hwdata2,
        input  hwrite_reg,
        input  hwrite_reg1,
        input  temp_selx,
        input  hrdata,
        input  hresp,
        input  hready_out
    );

endinterface

// File: rtl/ahb_slave_interface.sv
// -----------------------------------------------------------------------------
// ahb_slave_interface
//
// Purpose: AHB-facing front end of the AHB-to-APB bridge. Decodes the current
// address phase to a one-hot APB peripheral select, qualifies mapped transfers
// with 'valid', keeps one- and two-capture-delayed copies of address, write
// data and direction for the APB controller's pipelined writes, passes read
// data straight through, and issues the two-cycle AHB ERROR response for
// unmapped accesses.
//
// Ports:
//   hclk    in  bridge clock, all state updates on the rising edge
//   hreset  in  synchronous active-high reset
//   bus     slave modport of ahb_slave_interface_if (see that file)
//
// Address map:
//   0x8000_0000 - 0x83FF_FFFF -> 3'b001
//   0x8400_0000 - 0x87FF_FFFF -> 3'b010
//   0x8800_0000 - 0x8BFF_FFFF -> 3'b100
//   anything else             -> 3'b000 (unmapped)
// -----------------------------------------------------------------------------
module ahb_slave_interface (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_slave_interface_if.slave  bus
);

    // Response FSM: OKAY while no error is in progress, ERR1/ERR2 are the two
    // cycles of the AHB ERROR response. 2'b11 is unused and treated as OKAY.
    typedef enum logic [1:0] {
        ST_OKAY = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } resp_state_e;

    resp_state_e state_q;
    resp_state_e state_d;

    logic [31:0] haddr1_q;
    logic [31:0] haddr1_d;
    logic [31:0] haddr2_q;
    logic [31:0] haddr2_d;
    logic [31:0] hwdata1_q;
    logic [31:0] hwdata1_d;
    logic [31:0] hwdata2_q;
    logic [31:0] hwdata2_d;
    logic        hwrite1_q;
    logic        hwrite1_d;
    logic        hwrite2_q;
    logic        hwrite2_d;

    logic [2:0]  sel_s;
    logic        mapped_s;
    logic        active_s;
    logic        valid_s;
    logic        hresp_s;
    logic        hready_out_s;

    // Address decode against the fixed peripheral windows.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        if ((addr >= 32'h8000_0000) && (addr <= 32'h83FF_FFFF)) begin
            sel = 3'b001;
        end else if ((addr >= 32'h8400_0000) && (addr <= 32'h87FF_FFFF)) begin
            sel = 3'b010;
        end else if ((addr >= 32'h8800_0000) && (addr <= 32'h8BFF_FFFF)) begin
            sel = 3'b100;
        end else begin
            sel = 3'b000;
        end
        return sel;
    endfunction

    // Address-phase qualification: decode, active transfer detect, valid.
    always_comb begin
        sel_s    = decode_sel(bus.haddr);
        mapped_s = (sel_s != 3'b000);
        // NONSEQ or SEQ only; IDLE/BUSY never start a transfer or an error.
        active_s = bus.hready_in & ((bus.htrans == 2'b10) || (bus.htrans == 2'b11));
        // A mapped transfer seen during ERR2 is cancelled by the master, so
        // it must not be forwarded.
        if (state_q == ST_OKAY) begin
            valid_s = active_s & mapped_s;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Response FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OKAY: begin
                if (active_s && !mapped_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_OKAY;
                end
            end
            // Master is held off in ERR1, so nothing is sampled here.
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            // Back-to-back unmapped transfer restarts the error with no
            // intervening OKAY cycle.
            ST_ERR2: begin
                if (active_s && !mapped_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_OKAY;
                end
            end
            default: begin
                state_d = ST_OKAY;
            end
        endcase
    end

    // Response outputs decoded from the state register only.
    always_comb begin
        hresp_s      = 1'b0;
        hready_out_s = bus.hr_readyout;
        case (state_q)
            ST_OKAY: begin
                hresp_s      = 1'b0;
                hready_out_s = bus.hr_readyout;
            end
            ST_ERR1: begin
                hresp_s      = 1'b1;
                hready_out_s = 1'b0;
            end
            ST_ERR2: begin
                hresp_s      = 1'b1;
                hready_out_s = 1'b1;
            end
            default: begin
                hresp_s      = 1'b0;
                hready_out_s = bus.hr_readyout;
            end
        endcase
    end

    // Pipeline next-state: shift on hready_in, hold while stalled.
    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite1_d = hwrite1_q;
        hwrite2_d = hwrite2_q;
        if (bus.hready_in) begin
            haddr1_d  = bus.haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = bus.hwdata;
            hwdata2_d = hwdata1_q;
            hwrite1_d = bus.hwrite;
            hwrite2_d = hwrite1_q;
        end else begin
            haddr1_d  = haddr1_q;
            haddr2_d  = haddr2_q;
            hwdata1_d = hwdata1_q;
            hwdata2_d = hwdata2_q;
            hwrite1_d = hwrite1_q;
            hwrite2_d = hwrite2_q;
        end
    end

    // State and pipeline registers; reset overrides any capture or transition.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_OKAY;
            haddr1_q  <= 32'h0000_0000;
            haddr2_q  <= 32'h0000_0000;
            hwdata1_q <= 32'h0000_0000;
            hwdata2_q <= 32'h0000_0000;
            hwrite1_q <= 1'b0;
            hwrite2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite1_q <= hwrite1_d;
            hwrite2_q <= hwrite2_d;
        end
    end

    assign bus.valid       = valid_s;
    assign bus.temp_selx   = sel_s;
    assign bus.haddr1      = haddr1_q;
    assign bus.haddr2      = haddr2_q;
    assign bus.hwdata1     = hwdata1_q;
    assign bus.hwdata2     = hwdata2_q;
    assign bus.hwrite_reg  = hwrite1_q;
    assign bus.hwrite_reg1 = hwrite2_q;
    assign bus.hrdata      = bus.prdata;
    assign bus.hresp       = hresp_s;
    assign bus.hready_out  = hready_out_s;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_interface
//
// Self-checking bench for ahb_slave_interface. A behavioural model (history
// of captured beats plus a queue of pending error-response cycles) is updated
// on every rising edge and compared against every DUT output on each falling
// edge. Directed sequences additionally pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_ahb_slave_interface;

    logic hclk;
    logic hreset;

    ahb_slave_interface_if bus_if();

    ahb_slave_interface dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus_if)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model state: last two captured beats and pending response cycles.
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w1, m_w2;
    // Each entry is {hresp, hready_out} for one upcoming error cycle.
    logic [1:0]  resp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Peripheral index from the address window arithmetic.
    function automatic logic [2:0] m_sel(input logic [31:0] addr);
        logic [31:0] idx;
        if (addr >= 32'h8000_0000 && addr < 32'h8C00_0000) begin
            idx = (addr - 32'h8000_0000) / 32'h0400_0000;
            return 3'(1 << idx);
        end
        return 3'b000;
    endfunction

    function automatic bit m_active();
        return bus_if.hready_in && (bus_if.htrans >= 2'd2);
    endfunction

    // Model update at each rising edge.
    always @(posedge hclk) begin
        bit start_err;
        start_err = m_active() && (m_sel(bus_if.haddr) == 3'b000) && (resp_q.size() <= 1);
        if (hreset) begin
            m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_w1 = 0; m_w2 = 0;
            resp_q.delete();
        end else begin
            if (resp_q.size() > 0) void'(resp_q.pop_front());
            if (start_err) begin
                resp_q.push_back(2'b10);
                resp_q.push_back(2'b11);
            end
            if (bus_if.hready_in) begin
                m_a2 = m_a1; m_a1 = bus_if.haddr;
                m_d2 = m_d1; m_d1 = bus_if.hwdata;
                m_w2 = m_w1; m_w1 = bus_if.hwrite;
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge hclk) begin
        if (check_en) begin
            logic       e_valid;
            logic [1:0] e_resp;
            e_valid = m_active() && (m_sel(bus_if.haddr) != 3'b000) && (resp_q.size() == 0);
            e_resp  = (resp_q.size() == 0) ? {1'b0, bus_if.hr_readyout} : resp_q[0];
            chk("valid",       32'(bus_if.valid),       32'(e_valid));
            chk("temp_selx",   32'(bus_if.temp_selx),   32'(m_sel(bus_if.haddr)));
            chk("haddr1",      bus_if.haddr1,           m_a1);
            chk("haddr2",      bus_if.haddr2,           m_a2);
            chk("hwdata1",     bus_if.hwdata1,          m_d1);
            chk("hwdata2",     bus_if.hwdata2,          m_d2);
            chk("hwrite_reg",  32'(bus_if.hwrite_reg),  32'(m_w1));
            chk("hwrite_reg1", 32'(bus_if.hwrite_reg1), 32'(m_w2));
            chk("hrdata",      bus_if.hrdata,           bus_if.prdata);
            chk("hresp",       32'(bus_if.hresp),       32'(e_resp[1]));
            chk("hready_out",  32'(bus_if.hready_out),  32'(e_resp[0]));
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic rdy);
        bus_if.htrans    = tr;
        bus_if.hwrite    = wr;
        bus_if.haddr     = a;
        bus_if.hwdata    = d;
        bus_if.hready_in = rdy;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] b[6];
        b = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
              32'h8BFF_FFFF, 32'h8C00_0000};
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000 | ($urandom & 32'h03FF_FFFF);
            1: return 32'h8400_0000 | ($urandom & 32'h03FF_FFFF);
            2: return 32'h8800_0000 | ($urandom & 32'h03FF_FFFF);
            3: return b[$urandom_range(0, 5)];
            4: return $urandom & 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus_if.prdata      = 32'h0;
        bus_if.hr_readyout = 1'b1;
        // Reset with random inputs for two cycles.
        hreset = 1'b1;
        set_in(2'($urandom), 1'($urandom), $urandom, $urandom, 1'b1);
        bus_if.prdata = $urandom;
        step();
        check_en = 1'b1;
        step();
        hreset = 1'b0;
        #1;
        chk("rst_haddr1",  bus_if.haddr1, 32'h0);
        chk("rst_haddr2",  bus_if.haddr2, 32'h0);
        chk("rst_hwdata2", bus_if.hwdata2, 32'h0);
        chk("rst_hwrite1", 32'(bus_if.hwrite_reg1), 32'h0);
        chk("rst_hresp",   32'(bus_if.hresp), 32'h0);
        chk("rst_hready",  32'(bus_if.hready_out), 32'(bus_if.hr_readyout));

        // Mapped write and its two-stage pipeline.
        set_in(2'b10, 1'b1, 32'h8000_0010, 32'hA5A5_0001, 1'b1);
        #2;
        chk("wr_valid", 32'(bus_if.valid), 32'h1);
        chk("wr_sel",   32'(bus_if.temp_selx), 32'h1);
        step();
        set_in(2'b00, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
        #2;
        chk("wr_haddr1",  bus_if.haddr1, 32'h8000_0010);
        chk("wr_hwdata1", bus_if.hwdata1, 32'hA5A5_0001);
        chk("wr_hwrite",  32'(bus_if.hwrite_reg), 32'h1);
        step();
        #2;
        chk("wr_haddr2",  bus_if.haddr2, 32'h8000_0010);
        chk("wr_hwdata2", bus_if.hwdata2, 32'hA5A5_0001);
        chk("wr_hwrite1", 32'(bus_if.hwrite_reg1), 32'h1);

        // Decode sweep; the last address is unmapped and starts an error.
        set_in(2'b10, 1'b0, 32'h8400_0000, 32'h0, 1'b1);
        #2; chk("dec_sel0", 32'(bus_if.temp_selx), 32'h2); chk("dec_val0", 32'(bus_if.valid), 32'h1);
        step();
        set_in(2'b10, 1'b0, 32'h8BFF_FFFC, 32'h0, 1'b1);
        #2; chk("dec_sel1", 32'(bus_if.temp_selx), 32'h4); chk("dec_val1", 32'(bus_if.valid), 32'h1);
        step();
        set_in(2'b10, 1'b0, 32'h8C00_0000, 32'h0, 1'b1);
        #2; chk("dec_sel2", 32'(bus_if.temp_selx), 32'h0); chk("dec_val2", 32'(bus_if.valid), 32'h0);
        step();
        set_in(2'b00, 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        #2; chk("err_e1_resp", 32'(bus_if.hresp), 32'h1); chk("err_e1_rdy", 32'(bus_if.hready_out), 32'h0);
        step();
        #2; chk("err_e2_resp", 32'(bus_if.hresp), 32'h1); chk("err_e2_rdy", 32'(bus_if.hready_out), 32'h1);
        step();
        #2; chk("err_ok_resp", 32'(bus_if.hresp), 32'h0);

        // Stall: known history, then three cycles of hready_in = 0.
        set_in(2'b00, 1'b0, 32'h8000_00A0, 32'h0, 1'b1);
        step();
        set_in(2'b00, 1'b0, 32'h8000_00B0, 32'h0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b10, 1'b1, 32'h8000_1000 + 32'(i * 4), 32'h0, 1'b0);
            #2;
            chk("stall_valid",  32'(bus_if.valid), 32'h0);
            chk("stall_haddr1", bus_if.haddr1, 32'h8000_00B0);
            chk("stall_haddr2", bus_if.haddr2, 32'h8000_00A0);
            step();
        end

        // Back-to-back unmapped accesses: two consecutive error pairs.
        set_in(2'b10, 1'b0, 32'h0000_0004, 32'h0, 1'b1);
        step();
        set_in(2'b10, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
        #2; chk("b2b_e1a", {30'h0, bus_if.hresp, bus_if.hready_out}, 32'h2);
        step();
        #2; chk("b2b_e2a", {30'h0, bus_if.hresp, bus_if.hready_out}, 32'h3);
        step();
        set_in(2'b00, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
        #2; chk("b2b_e1b", {30'h0, bus_if.hresp, bus_if.hready_out}, 32'h2);
        step();
        #2; chk("b2b_e2b", {30'h0, bus_if.hresp, bus_if.hready_out}, 32'h3);
        step();
        #2; chk("b2b_ok", 32'(bus_if.hresp), 32'h0);

        // Reset during ERR1 ends the response immediately.
        set_in(2'b10, 1'b0, 32'h0000_0004, 32'h0, 1'b1);
        step();
        #2; chk("rerr_e1", 32'(bus_if.hresp), 32'h1);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        set_in(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("rerr_resp", 32'(bus_if.hresp), 32'h0);
        chk("rerr_rdy",  32'(bus_if.hready_out), 32'(bus_if.hr_readyout));

        // Read with combinational data pass-through.
        set_in(2'b10, 1'b0, 32'h8800_0000, 32'h0, 1'b1);
        bus_if.prdata = 32'h1234_5678;
        #2;
        chk("rd_valid",  32'(bus_if.valid), 32'h1);
        chk("rd_sel",    32'(bus_if.temp_selx), 32'h4);
        chk("rd_hrdata", bus_if.hrdata, 32'h1234_5678);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            set_in(2'($urandom), 1'($urandom), rand_addr(), $urandom,
                   ($urandom_range(0, 4) != 0));
            bus_if.prdata      = $urandom;
            bus_if.hr_readyout = ($urandom_range(0, 3) != 0);
            hreset             = ($urandom_range(0, 63) == 0);
            step();
        end
        hreset = 1'b0;
        step();
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

Front-end stage of the AHB-to-APB bridge, directly upstream of the APB controller. It samples the AHB master's address phase and data phase, decodes the address to an APB peripheral select, and generates the one- and two-cycle-delayed address, data and write copies the APB controller uses for pipelined writes. It also returns read data and a two-cycle AHB ERROR response for unmapped accesses, and merges its own stall with the controller's ready.

## Interface
Parameters:
- none; address map fixed below.

Ports:
- hclk  in  1  bridge clock; all state updates on rising edge.
- hreset  in  1  synchronous active-high reset.
- hwrite  in  1  AHB transfer direction (1 = write).
- hready_in  in  1  AHB HREADY seen by this slave.
- htrans  in  2  AHB transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- haddr  in  32  AHB address.
- hwdata  in  32  AHB write data.
- prdata  in  32  APB read data from the selected peripheral.
- hr_readyout  in  1  ready from the APB controller.
- valid  out  1  qualified, mapped transfer in the current address phase.
- haddr1, haddr2  out  32  haddr delayed 1 and 2 captures.
- hwdata1, hwdata2  out  32  hwdata delayed 1 and 2 captures.
- hwrite_reg, hwrite_reg1  out  1  hwrite delayed 1 and 2 captures.
- temp_selx  out  3  one-hot peripheral select decoded from haddr.
- hrdata  out  32  read data to the master.
- hresp  out  1  AHB response (0 OKAY, 1 ERROR).
- hready_out  out  1  HREADYOUT to the master.

## Operation
- Decode (combinational, from the current haddr):
  - 0x8000_0000–0x83FF_FFFF gives 3'b001.
  - 0x8400_0000–0x87FF_FFFF gives 3'b010.
  - 0x8800_0000–0x8BFF_FFFF gives 3'b100.
  - Any other address gives 3'b000, i.e. unmapped.
- active = hready_in & htrans[1] (NONSEQ or SEQ).
- valid = active & mapped & (state == OKAY). Combinational, same cycle as haddr.
- Pipeline registers capture only on a rising edge with hready_in = 1; otherwise they hold:
  - haddr1 <= haddr, haddr2 <= haddr1.
  - hwdata1 <= hwdata, hwdata2 <= hwdata1.
  - hwrite_reg <= hwrite, hwrite_reg1 <= hwrite_reg.
- hrdata = prdata, passed through combinationally.
- Response FSM, states OKAY, ERR1, ERR2:
  - OKAY to ERR1 when active and unmapped; otherwise stay in OKAY.
  - ERR1 always goes to ERR2.
  - ERR2 goes to ERR1 if active and unmapped; otherwise to OKAY.
- Outputs by state:
  - OKAY: hresp = 0, hready_out = hr_readyout.
  - ERR1: hresp = 1, hready_out = 0.
  - ERR2: hresp = 1, hready_out = 1.
  - hresp and hready_out are decoded combinationally from the state register.
- IDLE or BUSY to an unmapped address gives an OKAY response, no error, valid = 0.

## Timing
- Reset (hreset = 1 at an edge):
  - All pipeline registers clear to 0.
  - State returns to OKAY, so hresp = 0 and hready_out follows hr_readyout.
  - Reset wins over any capture or transition in the same edge.
  - Reset mid-error ends the ERROR response immediately after that edge.
- Latency:
  - valid and temp_selx: 0 cycles.
  - haddr1 / hwdata1 / hwrite_reg: 1 capture cycle.
  - haddr2 / hwdata2 / hwrite_reg1: 2 capture cycles.
- Stall: with hready_in = 0, all six pipeline registers hold and valid = 0.
- An error takes exactly 2 cycles; hready_out is low only in ERR1.
- Back-to-back unmapped transfers: the address sampled in ERR2 (hready_in = 1) restarts ERR1 with no OKAY cycle between.
- A mapped transfer in ERR2 produces valid = 0; the master cancels it, as AHB requires.

## Test plan
- Reset: hreset = 1 for 2 cycles with random inputs -> all registered outputs 0, hresp = 0, hready_out = hr_readyout.
- Mapped write: htrans = 10, hwrite = 1, haddr = 0x8000_0010, hwdata = 0xA5A5_0001, hready_in = 1 -> valid = 1 and temp_selx = 001 that cycle; next cycle haddr1 = 0x8000_0010, hwdata1 = 0xA5A5_0001, hwrite_reg = 1; the cycle after, the same values in haddr2, hwdata2, hwrite_reg1.
- Decode sweep: haddr = 0x8400_0000 / 0x8BFF_FFFC / 0x8C00_0000 with htrans = 10 -> temp_selx = 010 / 100 / 000, valid = 1 / 1 / 0.
- Stall: hready_in = 0 for 3 cycles while haddr changes -> haddr1 and haddr2 unchanged, valid = 0.
- Error: htrans = 10, haddr = 0x0000_0004 -> next cycle hresp = 1, hready_out = 0; following cycle hresp = 1, hready_out = 1; then OKAY. Repeat with back-to-back unmapped accesses -> two consecutive error pairs. Repeat with hreset asserted during ERR1 -> OKAY after that edge.
- Read: htrans = 10, hwrite = 0, haddr = 0x8800_0000, prdata = 0x1234_5678 -> valid = 1, temp_selx = 100, hrdata = 0x1234_5678 in the same cycle.
